// File: rtl/psum_accumulator.sv
// psum_accumulator: sums adder-tree results over acc_len terms, adds bias,
// then applies shift / ReLU / saturation and queues pixels toward writeback.
module psum_accumulator #(
  parameter int WIDTH      = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_acc_len,
  input  logic [LEN_WIDTH-1:0] cfg_out_num,
  input  logic [WIDTH-1:0]     cfg_bias,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
  input  logic [WIDTH-1:0]     indata,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;
  state_t state;

  // latched job configuration (lengths stored minus one)
  logic [LEN_WIDTH-1:0] acc_len_m1, out_num_m1;
  logic [WIDTH-1:0]     bias_r;
  logic [4:0]           shift_r;
  logic                 relu_r;

  logic [LEN_WIDTH-1:0] term_cnt, out_cnt;
  logic signed [ACC_WIDTH-1:0] acc, acc_base, acc_next, shifted;
  logic [OUT_WIDTH-1:0] result;

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic fifo_full, accept, last_term, push, pop;

  assign fifo_full = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign in_ready  = (state == ACC) && !fifo_full;
  assign busy      = (state != IDLE);
  // DRAIN lasts exactly until the FIFO empties, so this is a one-cycle pulse
  assign done      = (state == DRAIN) && (count == '0);
  assign accept    = in_valid && in_ready;
  assign last_term = (term_cnt == acc_len_m1);
  assign push      = accept && last_term;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // accumulate, then shift / ReLU / saturate the completed sum
  always_comb begin
    acc_base = (term_cnt == '0) ? ACC_WIDTH'($signed(bias_r)) : acc;
    acc_next = acc_base + ACC_WIDTH'($signed(indata));
    shifted  = acc_next >>> shift_r;
    if (relu_r && shifted[ACC_WIDTH-1]) shifted = '0;
    if (shifted > SAT_MAX)      result = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) result = SAT_MIN[OUT_WIDTH-1:0];
    else                        result = shifted[OUT_WIDTH-1:0];
  end

  // job FSM: config latch, term/output counting, accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      term_cnt   <= '0;
      out_cnt    <= '0;
      acc_len_m1 <= '0;
      out_num_m1 <= '0;
      bias_r     <= '0;
      shift_r    <= '0;
      relu_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc_len_m1 <= (cfg_acc_len == '0) ? '0 : cfg_acc_len - LEN_WIDTH'(1);
          out_num_m1 <= cfg_out_num - LEN_WIDTH'(1);
          bias_r     <= cfg_bias;
          shift_r    <= cfg_shift;
          relu_r     <= cfg_relu;
          term_cnt   <= '0;
          out_cnt    <= '0;
          state      <= (cfg_out_num == '0) ? DRAIN : ACC;
        end
        ACC: if (accept) begin
          acc <= acc_next;
          if (last_term) begin
            term_cnt <= '0;
            out_cnt  <= out_cnt + LEN_WIDTH'(1);
            if (out_cnt == out_num_m1) state <= DRAIN;
          end else begin
            term_cnt <= term_cnt + LEN_WIDTH'(1);
          end
        end
        DRAIN: if (count == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // output FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed + randomized bench for psum_accumulator with a job-level reference model.
module tb_psum_accumulator;
  localparam int WIDTH = 32, ACC_WIDTH = 40, OUT_WIDTH = 16, LEN_WIDTH = 16, FIFO_DEPTH = 4;

  logic clk = 0, rst = 1, start = 0, cfg_relu = 0, in_valid = 0, out_ready = 0;
  logic [LEN_WIDTH-1:0] cfg_acc_len = '0, cfg_out_num = '0;
  logic [WIDTH-1:0] cfg_bias = '0, indata = '0;
  logic [4:0] cfg_shift = '0;
  logic in_ready, out_valid, busy, done;
  logic [OUT_WIDTH-1:0] out_data;

  int n_assert = 0, n_fail = 0;
  int terms[$];

  psum_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
                     .LEN_WIDTH(LEN_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_acc_len(cfg_acc_len), .cfg_out_num(cfg_out_num),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .indata(indata),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: what each output pixel must be, from plain integer arithmetic
  function automatic longint model_pixel(longint bias, int len, int first, int sh, bit relu);
    longint s, d, v;
    s = bias;
    for (int t = 0; t < len; t++) s += terms[first + t];
    s = (s <<< (64 - ACC_WIDTH)) >>> (64 - ACC_WIDTH);   // accumulator wraps at ACC_WIDTH
    d = longint'(1) <<< sh;
    v = (s >= 0) ? s / d : -((-s + d - 1) / d);            // floor division
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic run_job(input int len, input int num, input int bias, input int sh,
                         input bit relu, input int hold, input bit poke);
    longint exp_q[$];
    int len_e, total, fed, popped, cyc, last_pop, outstanding;
    bit done_seen, prev_stall;
    logic [OUT_WIDTH-1:0] prev_data;
    len_e = (len == 0) ? 1 : len;
    total = len_e * num;
    for (int o = 0; o < num; o++) exp_q.push_back(model_pixel(bias, len_e, o * len_e, sh, relu));
    fed = 0; popped = 0; cyc = 0; last_pop = -1; done_seen = 0; prev_stall = 0; prev_data = '0;

    @(negedge clk);
    cfg_acc_len = LEN_WIDTH'(len); cfg_out_num = LEN_WIDTH'(num);
    cfg_bias = WIDTH'(bias); cfg_shift = 5'(sh); cfg_relu = relu; start = 1;
    in_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    chk("busy_after_start", busy, 1);

    while (cyc < 3000 && !done_seen) begin
      @(negedge clk);
      start = 0;
      if (poke && cyc == 3) begin
        start = 1; cfg_acc_len = LEN_WIDTH'($urandom_range(7)); cfg_out_num = '0;
        cfg_bias = $urandom; cfg_shift = 5'($urandom); cfg_relu = ~relu;
      end
      in_valid  = (cyc < hold) ? 1'b1 : ($urandom_range(3) != 0);
      indata    = (fed < total) ? WIDTH'(terms[fed]) : $urandom;
      out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(3) != 0);
      #1;
      if (hold > 0 && cyc == hold)
        chk("fed_while_blocked", fed, (total < FIFO_DEPTH * len_e) ? total : FIFO_DEPTH * len_e);
      outstanding = fed / len_e - popped;
      chk("in_ready", in_ready, (fed < total) && (outstanding < FIFO_DEPTH));
      chk("out_valid", out_valid, outstanding > 0);
      chk("done", done, (fed == total) && (outstanding == 0));
      if (prev_stall) chk("out_data_hold", out_data, prev_data);
      if (in_valid && in_ready && fed < total) fed++;
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) chk("out_data", $signed(out_data), exp_q.pop_front());
        else chk("extra_output", popped, num - 1);
        popped++; last_pop = cyc;
      end
      if (done) begin
        done_seen = 1;
        if (num > 0) chk("done_after_last_pop", cyc, last_pop + 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      cyc++;
    end
    chk("job_timeout", done_seen, 1);
    chk("outputs_popped", popped, num);
    @(negedge clk);
    start = 0; in_valid = 0; out_ready = 0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst = 0;

    // basic: 16, -5
    terms = '{1, 2, 3, -4, -5, -6};
    chk("model_basic0", model_pixel(10, 3, 0, 0, 0), 16);
    chk("model_basic1", model_pixel(10, 3, 3, 0, 0), -5);
    run_job(3, 2, 10, 0, 0, 0, 0);

    // shift/relu: 0, 3 then -2, 3
    terms = '{-7, 13};
    run_job(1, 2, 0, 2, 1, 0, 0);
    chk("model_floor", model_pixel(0, 1, 0, 2, 0), -2);
    run_job(1, 2, 0, 2, 0, 0, 0);

    // saturation both ways
    terms = '{40000, 40000, -40000, -40000};
    run_job(2, 2, 0, 0, 0, 0, 0);

    // backpressure: FIFO fills after 4 terms while out_ready is low
    terms.delete();
    for (int i = 0; i < 6; i++) terms.push_back(int'($urandom_range(2000)) - 1000);
    run_job(1, 6, 5, 0, 0, 10, 0);

    // acc_len = 0 behaves as 1
    terms.delete();
    for (int i = 0; i < 3; i++) terms.push_back(int'($urandom_range(60000)) - 30000);
    run_job(0, 3, -7, 0, 0, 0, 0);

    // empty job
    run_job(2, 0, 0, 0, 0, 0, 0);

    // start during ACC must not disturb the running job
    terms.delete();
    for (int i = 0; i < 12; i++) terms.push_back(int'($urandom_range(4000)) - 2000);
    run_job(4, 3, 100, 1, 0, 0, 1);

    // random jobs over full-range terms
    for (int j = 0; j < 5; j++) begin
      int len, num;
      len = $urandom_range(5, 1); num = $urandom_range(5, 1);
      terms.delete();
      for (int i = 0; i < len * num; i++) terms.push_back(int'($urandom));
      run_job(len, num, int'($urandom), $urandom_range(31), 1'($urandom), 0, 0);
    end

    // reset mid-job with two queued outputs and a partial sum
    @(negedge clk);
    cfg_acc_len = 3; cfg_out_num = 5; cfg_bias = 1000; cfg_shift = 0; cfg_relu = 0; start = 1;
    @(negedge clk); start = 0; out_ready = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; indata = WIDTH'(500 + i);
      @(negedge clk);
    end
    in_valid = 0; rst = 1;
    @(negedge clk); rst = 0; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_done", done, 0);
    terms = '{1, 2, 3, -4, -5, -6};
    run_job(3, 2, 10, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
